// File: rtl/se_pkg.sv
// Shared encodings and field-position helpers for the select-and-encode sequencer.
package se_pkg;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_I  = 2'd1,
    FMT_BR = 2'd2,
    FMT_ST = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    PH3  = 2'd3
  } phase_e;

  function automatic int rf_w(input int nreg);
    return $clog2(nreg);
  endfunction

  // Register fields are packed directly below the opcode: ra, rb, rc.
  function automatic int ra_lsb(input int nreg, input int data_w, input int op_w);
    return data_w - op_w - rf_w(nreg);
  endfunction

  function automatic int rb_lsb(input int nreg, input int data_w, input int op_w);
    return ra_lsb(nreg, data_w, op_w) - rf_w(nreg);
  endfunction

  function automatic int rc_lsb(input int nreg, input int data_w, input int op_w);
    return rb_lsb(nreg, data_w, op_w) - rf_w(nreg);
  endfunction

  // The immediate overlaps rc and everything below it.
  function automatic int imm_w(input int nreg, input int data_w, input int op_w);
    return rc_lsb(nreg, data_w, op_w) + rf_w(nreg);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder with a global enable.
module onehot_dec #(
  parameter int N = 16
) (
  input  logic [$clog2(N)-1:0] idx,
  input  logic                 en,
  output logic [N-1:0]         onehot
);

  localparam int W = $clog2(N);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/se_logic_seq.sv
// Sequenced operand select/encode unit: holds the IR, walks B / C-or-IMM / A phases
// and drives one-hot register enables, selects and the sign-extended constant.
module se_logic_seq
  import se_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              start,
  input  logic [1:0]        fmt,
  input  logic              stall,
  output logic [OP_W-1:0]   op,
  output logic [NREG-1:0]   ren,
  output logic [NREG-1:0]   rsel,
  output logic              c_out,
  output logic [DATA_W-1:0] c_ext,
  output logic              r0_zero,
  output logic              busy,
  output logic              done
);

  localparam int RF_W   = rf_w(NREG);
  localparam int RA_LSB = ra_lsb(NREG, DATA_W, OP_W);
  localparam int RB_LSB = rb_lsb(NREG, DATA_W, OP_W);
  localparam int RC_LSB = rc_lsb(NREG, DATA_W, OP_W);
  localparam int IMM_W  = imm_w(NREG, DATA_W, OP_W);

  phase_e            state_reg;
  fmt_e              fmt_reg;
  logic [DATA_W-1:0] ir_reg;

  logic [RF_W-1:0] ra, rb, rc;
  logic [RF_W-1:0] dec_idx;
  logic            dec_en;
  logic            wr_sel;
  logic [NREG-1:0] dec_onehot;

  assign ra = ir_reg[RA_LSB +: RF_W];
  assign rb = ir_reg[RB_LSB +: RF_W];
  assign rc = ir_reg[RC_LSB +: RF_W];

  // stall freezes everything, including acceptance of ir_load/start in IDLE.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= IDLE;
      fmt_reg   <= FMT_R;
      ir_reg    <= '0;
    end else if (!stall) begin
      unique case (state_reg)
        IDLE: begin
          if (ir_load) ir_reg <= ir_in;
          if (start) begin
            fmt_reg   <= fmt_e'(fmt);
            state_reg <= PH1;
          end
        end
        PH1:     state_reg <= PH2;
        PH2:     state_reg <= (fmt_reg == FMT_BR) ? IDLE : PH3;
        PH3:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    dec_en  = 1'b0;
    dec_idx = rb;
    wr_sel  = 1'b0;
    c_out   = 1'b0;
    r0_zero = 1'b0;
    done    = 1'b0;
    unique case (state_reg)
      PH1: begin
        unique case (fmt_reg)
          FMT_R: begin
            dec_en  = 1'b1;
            dec_idx = rb;
          end
          FMT_BR: begin
            dec_en  = 1'b1;
            dec_idx = ra;
          end
          default: begin
            // Base register R0 reads as zero rather than selecting R0.
            if (rb != '0) begin
              dec_en  = 1'b1;
              dec_idx = rb;
            end else begin
              r0_zero = 1'b1;
            end
          end
        endcase
      end
      PH2: begin
        if (fmt_reg == FMT_R) begin
          dec_en  = 1'b1;
          dec_idx = rc;
        end else begin
          c_out = 1'b1;
          done  = (fmt_reg == FMT_BR);
        end
      end
      PH3: begin
        dec_en  = 1'b1;
        dec_idx = ra;
        wr_sel  = (fmt_reg != FMT_ST);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec #(.N(NREG)) u_dec (
    .idx    (dec_idx),
    .en     (dec_en),
    .onehot (dec_onehot)
  );

  assign ren   = wr_sel ? dec_onehot : '0;
  assign rsel  = wr_sel ? '0 : dec_onehot;
  assign busy  = (state_reg != IDLE);
  assign op    = ir_reg[DATA_W-1 -: OP_W];
  assign c_ext = {{(DATA_W-IMM_W){ir_reg[IMM_W-1]}}, ir_reg[IMM_W-1:0]};

endmodule

// File: tb/tb_se_logic_seq.sv
// Directed self-checking bench for se_logic_seq at NREG=16 and NREG=32.
module tb_se_logic_seq;

  logic        clock;
  logic        clear_n;
  logic        ir_load;
  logic [31:0] ir_in;
  logic        start;
  logic [1:0]  fmt;
  logic        stall;

  logic [4:0]  op;
  logic [15:0] ren, rsel;
  logic        c_out, r0_zero, busy, done;
  logic [31:0] c_ext;

  logic [4:0]  op2;
  logic [31:0] ren2, rsel2;
  logic        c_out2, r0_zero2, busy2, done2;
  logic [31:0] c_ext2;

  int n_tests = 0;
  int n_fail  = 0;

  se_logic_seq #(.NREG(16), .DATA_W(32), .OP_W(5)) dut (
    .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .ir_in(ir_in),
    .start(start), .fmt(fmt), .stall(stall), .op(op), .ren(ren), .rsel(rsel),
    .c_out(c_out), .c_ext(c_ext), .r0_zero(r0_zero), .busy(busy), .done(done)
  );

  se_logic_seq #(.NREG(32), .DATA_W(32), .OP_W(5)) dut32 (
    .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .ir_in(ir_in),
    .start(start), .fmt(fmt), .stall(stall), .op(op2), .ren(ren2), .rsel(rsel2),
    .c_out(c_out2), .c_ext(c_ext2), .r0_zero(r0_zero2), .busy(busy2), .done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where PH1 is visible.
  task automatic run_start(input logic [31:0] ir, input logic [1:0] f);
    ir_in   = ir;
    ir_load = 1'b1;
    start   = 1'b1;
    fmt     = f;
    tick();
    ir_load = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0;
    ir_load = 1'b0;
    ir_in   = '0;
    start   = 1'b0;
    fmt     = 2'd0;
    stall   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ren", ren, 0);
    check("rst_rsel", rsel, 0);
    check("rst_op", op, 0);
    check("rst_cext", c_ext, 0);
    check("rst_done", done, 0);
    clear_n = 1'b1;
    tick();
    $display("[TB] reset checked");

    // R-type 0x00A98000: ra=1 rb=5 rc=3
    run_start(32'h00A9_8000, 2'd0);
    check("r_ph1_rsel", rsel, 16'h0020);
    check("r_ph1_ren", ren, 0);
    check("r_ph1_busy", busy, 1);
    check("r_ph1_done", done, 0);
    tick();
    check("r_ph2_rsel", rsel, 16'h0008);
    check("r_ph2_cout", c_out, 0);
    tick();
    check("r_ph3_ren", ren, 16'h0002);
    check("r_ph3_rsel", rsel, 0);
    check("r_ph3_done", done, 1);
    tick();
    check("r_idle_busy", busy, 0);
    check("r_idle_done", done, 0);
    check("r_idle_cext", c_ext, 32'h0001_8000);
    $display("[TB] R-type sequence ir=00a98000");

    // I-type op=5 ra=2 rb=0 imm=0x7FFFF
    run_start(32'h2907_FFFF, 2'd1);
    check("i_op", op, 5);
    check("i_ph1_rsel", rsel, 0);
    check("i_ph1_r0z", r0_zero, 1);
    tick();
    check("i_ph2_cout", c_out, 1);
    check("i_ph2_cext", c_ext, 32'hFFFF_FFFF);
    check("i_ph2_rsel", rsel, 0);
    check("i_ph2_done", done, 0);
    tick();
    check("i_ph3_ren", ren, 16'h0004);
    check("i_ph3_done", done, 1);
    check("i_ph3_cout", c_out, 0);
    tick();
    $display("[TB] I-type sequence ir=2907ffff");

    // BR ra=7 imm=0x123, stalled three cycles in PH2
    run_start(32'h0380_0123, 2'd2);
    check("br_ph1_rsel", rsel, 16'h0080);
    check("br_ph1_ren", ren, 0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("br_ph2_cout", c_out, 1);
      check("br_ph2_done", done, 1);
      check("br_ph2_cext", c_ext, 32'h0000_0123);
      if (i < 3) tick();
    end
    stall = 1'b0;
    tick();
    check("br_end_busy", busy, 0);
    check("br_end_done", done, 0);
    check("br_end_cout", c_out, 0);
    $display("[TB] BR sequence with stall ir=03800123");

    // R-type aborted by clear_n in PH2
    run_start(32'h48A9_8000, 2'd0);
    check("ab_op", op, 9);
    tick();
    check("ab_ph2_rsel", rsel, 16'h0008);
    clear_n = 1'b0;
    #1;
    check("ab_busy", busy, 0);
    check("ab_ren", ren, 0);
    check("ab_rsel", rsel, 0);
    check("ab_op_clr", op, 0);
    check("ab_cext_clr", c_ext, 0);
    tick();
    clear_n = 1'b1;
    tick();
    check("ab_noresume", busy, 0);
    check("ab_nodone", done, 0);
    $display("[TB] R-type aborted by clear_n");

    // start/ir_load while busy are ignored
    run_start(32'h00A9_8000, 2'd0);
    ir_in   = 32'hFFFF_FFFF;
    ir_load = 1'b1;
    start   = 1'b1;
    fmt     = 2'd1;
    tick();
    check("bz_ph2_rsel", rsel, 16'h0008);
    check("bz_op", op, 0);
    tick();
    check("bz_ph3_ren", ren, 16'h0002);
    check("bz_ph3_done", done, 1);
    ir_load = 1'b0;
    start   = 1'b0;
    tick();
    check("bz_idle_busy", busy, 0);
    check("bz_idle_op", op, 0);
    $display("[TB] busy start/ir_load ignored");

    // ST-type ra=6 rb=4 accepted from IDLE
    run_start(32'h0320_0000, 2'd3);
    check("st_ph1_rsel", rsel, 16'h0010);
    check("st_ph1_r0z", r0_zero, 0);
    tick();
    check("st_ph2_cout", c_out, 1);
    check("st_ph2_cext", c_ext, 0);
    tick();
    check("st_ph3_rsel", rsel, 16'h0040);
    check("st_ph3_ren", ren, 0);
    check("st_ph3_done", done, 1);
    tick();
    $display("[TB] ST-type sequence ir=03200000");

    // NREG=32 instance: ra=31 rb=1 rc=2
    run_start(32'h07C2_2000, 2'd0);
    check("n32_ph1_rsel", rsel2, 32'h0000_0002);
    tick();
    check("n32_ph2_rsel", rsel2, 32'h0000_0004);
    tick();
    check("n32_ph3_ren", ren2, 32'h8000_0000);
    check("n32_ph3_done", done2, 1);
    check("n32_cext", c_ext2, 32'h0000_2000);
    tick();
    check("n32_idle_busy", busy2, 0);
    $display("[TB] NREG=32 R-type sequence ir=07c22000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
